// File: rtl/mem_load_pkg.sv
// rtl/mem_load_pkg.sv - shared encodings for the data-memory load unit
// Purpose: load op encodings, FSM state encoding, error bit indices and the
//          legal-op decode used by mem_load_unit and load_extract.
// Ports:   none (package).
package mem_load_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_TIMEOUT = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } ld_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: is_legal_op = 1'b1;
            default:                             is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - big-endian lane select with sign/zero extension
// Purpose: picks the byte/half lane of a 32-bit memory word (byte 0 = bits 31:24)
//          and extends it according to the load op.
// Ports:   word_i    32-bit memory word
//          op_i      load op encoding
//          addr_lo_i byte address bits [1:0]
//          data_o    extended load result (0 for illegal ops)
module load_extract
    import mem_load_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_i)
            2'd0: byte_sel = word_i[31:24];
            2'd1: byte_sel = word_i[23:16];
            2'd2: byte_sel = word_i[15:8];
            2'd3: byte_sel = word_i[7:0];
            default: byte_sel = 8'h00;
        endcase
        // addr[0] plays no part in half selection; misalignment is handled upstream
        half_sel = addr_lo_i[1] ? word_i[15:0] : word_i[31:16];
    end

    always_comb begin
        data_o = 32'h0;
        case (op_i)
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {24'h0, byte_sel};
            LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data_o = {16'h0, half_sel};
            LD_LW:   data_o = word_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - MIPS32 data-memory load unit (LB/LBU/LH/LHU/LW)
// Purpose: accepts one load at a time, issues a word-aligned read, waits for the
//          variable-latency return (with timeout) and returns the extended result.
// Config:  MEM_LOAD_ALIGN_CHECK_EN - when defined, misaligned LH/LHU/LW are rejected
//          as illegal without a memory access.
// Ports:   CLK, reset (async active-low)
//          req_valid/req_ready/req_op/req_addr/req_rd  - load request handshake
//          mem_re/mem_addr/mem_rdata/mem_rvalid         - data memory read port
//          rsp_valid/rsp_data/rsp_rd/error              - result pulse and held fields
module mem_load_unit
    import mem_load_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_rd,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic [1:0]        error
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    ld_state_e         state_q,    state_d;
    logic [2:0]        op_q,       op_d;
    logic [1:0]        addr_lo_q,  addr_lo_d;
    logic [4:0]        rd_q,       rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [TMR_W-1:0]  timer_q,    timer_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [4:0]        rsp_rd_q,   rsp_rd_d;
    logic [1:0]        error_q,    error_d;

    logic [31:0] ext_data;
    logic        req_bad;
    logic        misaligned;

    load_extract u_extract (
        .word_i    (mem_rdata),
        .op_i      (op_q),
        .addr_lo_i (addr_lo_q),
        .data_o    (ext_data)
    );

`ifdef MEM_LOAD_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if ((req_op == LD_LH || req_op == LD_LHU) && req_addr[0])
            misaligned = 1'b1;
        if (req_op == LD_LW && req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
    end
`else
    assign misaligned = 1'b0;
`endif

    assign req_bad = !is_legal_op(req_op) || misaligned;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_lo_d  = addr_lo_q;
        rd_d       = rd_q;
        mem_addr_d = mem_addr_q;
        timer_d    = timer_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    addr_lo_d = req_addr[1:0];
                    rd_d      = req_rd;
                    timer_d   = '0;
                    if (req_bad) begin
                        // rejected requests answer straight away, memory untouched
                        state_d              = S_RESP;
                        rsp_data_d           = 32'h0;
                        rsp_rd_d             = req_rd;
                        error_d              = 2'b00;
                        error_d[ERR_ILLEGAL] = 1'b1;
                    end else begin
                        state_d    = S_ISSUE;
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                // data arriving on the last timer cycle still wins over the timeout
                if (mem_rvalid) begin
                    state_d    = S_RESP;
                    rsp_data_d = ext_data;
                    rsp_rd_d   = rd_q;
                    error_d    = 2'b00;
                end else if (timer_q == TMR_LAST) begin
                    state_d              = S_RESP;
                    rsp_data_d           = 32'h0;
                    rsp_rd_d             = rd_q;
                    error_d              = 2'b00;
                    error_d[ERR_TIMEOUT] = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= 3'b000;
            addr_lo_q  <= 2'b00;
            rd_q       <= 5'd0;
            mem_addr_q <= '0;
            timer_q    <= '0;
            rsp_data_q <= 32'h0;
            rsp_rd_q   <= 5'd0;
            error_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_lo_q  <= addr_lo_d;
            rd_q       <= rd_d;
            mem_addr_q <= mem_addr_d;
            timer_q    <= timer_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
            error_q    <= error_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_re    = (state_q == S_ISSUE);
    assign rsp_valid = (state_q == S_RESP);
    assign mem_addr  = mem_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - directed self-checking bench for mem_load_unit
module tb_mem_load_unit;

    logic        CLK;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [1:0]  error;

    int checks   = 0;
    int failures = 0;

    // memory model state
    logic        model_en    = 1'b1;
    int          lat         = 1;
    logic        model_rvalid = 1'b0;
    logic        inj_rvalid  = 1'b0;
    logic [31:0] model_data  = 32'h0;
    logic        pend        = 1'b0;
    int          cnt         = 0;
    int          re_count    = 0;

    assign mem_rvalid = model_rvalid | inj_rvalid;
    assign mem_rdata  = mem_rvalid ? model_data : 32'h0;

    mem_load_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_rd     (req_rd),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .error      (error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data memory: 0xAABBCCDD at 0x100; rvalid 'lat' cycles after the mem_re cycle.
    always @(negedge CLK) begin
        model_rvalid = 1'b0;
        if (mem_re) begin
            re_count++;
            if (model_en) begin
                pend       = 1'b1;
                cnt        = lat;
                model_data = (mem_addr == 32'h100) ? 32'hAABBCCDD : 32'h11223344;
            end
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                model_rvalid = 1'b1;
                pend         = 1'b0;
            end
        end
    end

    // Drives one request at a negedge (cycle 0) and waits for rsp_valid;
    // lat_k is the number of cycles from accept to rsp_valid (-1 if none).
    task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                            output int lat_k, output logic [31:0] d, output logic [4:0] r,
                            output logic [1:0] e, output logic [31:0] maddr, output int re_delta);
        int re0;
        re0   = re_count;
        lat_k = -1;
        d     = 32'hx;
        r     = 5'hx;
        e     = 2'hx;
        maddr = 32'hx;
        @(negedge CLK);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_rd    = rd;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            if (k == 1) maddr = mem_addr;
            if (rsp_valid) begin
                lat_k = k;
                d     = rsp_data;
                r     = rsp_rd;
                e     = error;
                break;
            end
        end
        re_delta = re_count - re0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0;
        req_rd    = 5'd0;
        repeat (2) @(negedge CLK);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL reset_mem_re got=%b exp=0", mem_re); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if ({rsp_data, rsp_rd, error} !== 39'h0) begin failures++; $display("FAIL reset_rsp_fields got=%h/%h/%b exp=0", rsp_data, rsp_rd, error); end
        reset = 1'b1;
        @(negedge CLK);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got ready=%b rsp_valid=%b exp 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_lanes();
        logic [2:0]  ops  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
        logic [31:0] adrs [5] = '{32'h101, 32'h103, 32'h100, 32'h102, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFFFFBB, 32'h000000DD, 32'hFFFFAABB, 32'h0000CCDD, 32'hAABBCCDD};
        int lk, rdl;
        logic [31:0] d, ma;
        logic [4:0]  r;
        logic [1:0]  e;
        lat = 1;
        for (int i = 0; i < 5; i++) begin
            run_load(ops[i], adrs[i], 5'(i + 1), lk, d, r, e, ma, rdl);
            checks++; if (d !== exps[i]) begin failures++; $display("FAIL lane_data[%0d] got=%h exp=%h", i, d, exps[i]); end
            checks++; if (lk !== 3) begin failures++; $display("FAIL lane_latency[%0d] got=%0d exp=3", i, lk); end
            checks++; if (e !== 2'b00 || r !== 5'(i + 1)) begin failures++; $display("FAIL lane_err_rd[%0d] got=%b/%0d exp=00/%0d", i, e, r, i + 1); end
            checks++; if (ma !== 32'h100 || rdl !== 1) begin failures++; $display("FAIL lane_mem[%0d] got addr=%h re=%0d exp 100/1", i, ma, rdl); end
        end
    endtask

    task automatic test_back_to_back();
        int re0, ready_hi, rsp_k1, rsp_k2;
        logic [31:0] d1, d2;
        logic [4:0]  r1, r2;
        lat      = 5;
        re0      = re_count;
        ready_hi = 0;
        rsp_k1   = -1;
        rsp_k2   = -1;
        d1 = 32'hx; d2 = 32'hx; r1 = 5'hx; r2 = 5'hx;
        @(negedge CLK);
        req_valid = 1'b1;
        req_op    = 3'b011;
        req_addr  = 32'h100;
        req_rd    = 5'd9;
        for (int k = 1; k <= 30; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                // second request held pending from the first ISSUE cycle on
                req_op   = 3'b100;
                req_addr = 32'h103;
                req_rd   = 5'd3;
            end
            if (k == 9) req_valid = 1'b0;
            if (k <= 7 && req_ready) ready_hi++;
            if (rsp_valid && rsp_k1 < 0) begin rsp_k1 = k; d1 = rsp_data; r1 = rsp_rd; end
            else if (rsp_valid && rsp_k2 < 0) begin rsp_k2 = k; d2 = rsp_data; r2 = rsp_rd; end
            if (k == 7) begin
                checks++; if (re_count - re0 !== 1) begin failures++; $display("FAIL b2b_single_mem_re got=%0d exp=1", re_count - re0); end
            end
        end
        checks++; if (ready_hi !== 0) begin failures++; $display("FAIL b2b_ready_low got=%0d high cycles exp=0", ready_hi); end
        checks++; if (rsp_k1 !== 7 || d1 !== 32'hAABBCCDD || r1 !== 5'd9) begin failures++; $display("FAIL b2b_first got k=%0d d=%h rd=%0d exp 7/aabbccdd/9", rsp_k1, d1, r1); end
        checks++; if (rsp_k2 !== 15 || d2 !== 32'h000000DD || r2 !== 5'd3) begin failures++; $display("FAIL b2b_second got k=%0d d=%h rd=%0d exp 15/000000dd/3", rsp_k2, d2, r2); end
        lat = 1;
    endtask

    task automatic test_timeout();
        int lk, rdl, late_rsp;
        logic [31:0] d, ma;
        logic [4:0]  r;
        logic [1:0]  e;
        model_en = 1'b0;
        run_load(3'b011, 32'h100, 5'd4, lk, d, r, e, ma, rdl);
        checks++; if (lk !== 18) begin failures++; $display("FAIL timeout_latency got=%0d exp=18", lk); end
        checks++; if (e !== 2'b10 || d !== 32'h0 || r !== 5'd4) begin failures++; $display("FAIL timeout_rsp got err=%b d=%h rd=%0d exp 10/0/4", e, d, r); end
        checks++; if (rdl !== 1) begin failures++; $display("FAIL timeout_mem_re got=%0d exp=1", rdl); end
        @(negedge CLK);
        inj_rvalid = 1'b1;
        @(negedge CLK);
        inj_rvalid = 1'b0;
        late_rsp = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid || !req_ready) late_rsp++;
            @(negedge CLK);
        end
        checks++; if (late_rsp !== 0 || error !== 2'b10) begin failures++; $display("FAIL timeout_late_rvalid got busy=%0d err=%b exp 0/10", late_rsp, error); end
        model_en = 1'b1;
    endtask

    task automatic test_illegal();
        int lk, rdl;
        logic [31:0] d, ma;
        logic [4:0]  r;
        logic [1:0]  e;
        run_load(3'b111, 32'h100, 5'd12, lk, d, r, e, ma, rdl);
        checks++; if (lk !== 1 || rdl !== 0) begin failures++; $display("FAIL illegal_op_path got k=%0d re=%0d exp 1/0", lk, rdl); end
        checks++; if (e !== 2'b01 || d !== 32'h0 || r !== 5'd12) begin failures++; $display("FAIL illegal_op_rsp got err=%b d=%h rd=%0d exp 01/0/12", e, d, r); end
        run_load(3'b001, 32'h101, 5'd13, lk, d, r, e, ma, rdl);
`ifdef MEM_LOAD_ALIGN_CHECK_EN
        checks++; if (lk !== 1 || rdl !== 0) begin failures++; $display("FAIL misaligned_lh_path got k=%0d re=%0d exp 1/0", lk, rdl); end
        checks++; if (e !== 2'b01 || d !== 32'h0) begin failures++; $display("FAIL misaligned_lh_rsp got err=%b d=%h exp 01/0", e, d); end
`else
        checks++; if (lk !== 3 || rdl !== 1) begin failures++; $display("FAIL unaligned_lh_path got k=%0d re=%0d exp 3/1", lk, rdl); end
        checks++; if (e !== 2'b00 || d !== 32'hFFFFAABB) begin failures++; $display("FAIL unaligned_lh_rsp got err=%b d=%h exp 00/ffffaabb", e, d); end
`endif
    endtask

    task automatic test_reset_mid();
        int lk, rdl, stray;
        logic [31:0] d, ma;
        logic [4:0]  r;
        logic [1:0]  e;
        lat = 1;
        run_load(3'b011, 32'h100, 5'd5, lk, d, r, e, ma, rdl);
        checks++; if (d !== 32'hAABBCCDD || r !== 5'd5) begin failures++; $display("FAIL pre_abort_load got d=%h rd=%0d exp aabbccdd/5", d, r); end
        lat = 5;
        @(negedge CLK);
        req_valid = 1'b1;
        req_op    = 3'b011;
        req_addr  = 32'h100;
        req_rd    = 5'd7;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_re !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_ctrl got ready=%b re=%b rsp=%b exp 1/0/0", req_ready, mem_re, rsp_valid); end
        checks++; if (mem_addr !== 32'h0 || rsp_data !== 32'h0 || rsp_rd !== 5'd0 || error !== 2'b00) begin failures++; $display("FAIL abort_fields got addr=%h d=%h rd=%0d err=%b exp 0", mem_addr, rsp_data, rsp_rd, error); end
        @(negedge CLK);
        reset = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (rsp_valid) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL abort_no_rsp got=%0d pulses exp=0", stray); end
        lat = 1;
        run_load(3'b100, 32'h100, 5'd6, lk, d, r, e, ma, rdl);
        checks++; if (d !== 32'h000000AA || lk !== 3 || e !== 2'b00 || r !== 5'd6) begin failures++; $display("FAIL post_abort_lbu got d=%h k=%0d err=%b rd=%0d exp 000000aa/3/00/6", d, lk, e, r); end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
